fc_controller: RTL and testbench
================================

# fc_controller

Sequencer for the fully-connected engine. It accepts the level-held `fc_lif_start`, `fc_lw_start` and `fc_sof_start` commands from the instruction decoder and moves data between external memory and the FC buffers:

- input-feature loads,
- weight loads split into row partitions,
- output-feature stores.

It hands each weight partition to the PE array and reports progress back to the decoder through `fc_next_partition` and `fc_done`.

## Interface
- `PART_ROWS`, 16: output rows per weight partition (power of two, at least 1).
- `DATA_W`, 32: memory and buffer word width.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: synchronous, active-low reset, sampled on rising `clk`.
- `fc_rst` input, 1 bit: abort to IDLE (same effect as reset).
- `fc_cin`, `fc_cout` input, 12 bits each: layer dimensions, latched at command accept.
- `fc_lif_start`, `fc_lw_start`, `fc_sof_start` input, 1 bit each: command levels, held until `fc_done`.
- `base_addr` input, 27 bits: word base address, latched at accept.
- `fc_next_partition` output, 1 bit: one-cycle pulse when a non-final weight partition finishes.
- `fc_done` output, 1 bit: one-cycle pulse when the command completes.
- `mem_req`, `mem_we` output, 1 bit each: memory request and write select.
- `mem_addr` output, 27 bits: memory word address.
- `mem_wdata` output, `DATA_W` bits: memory write data.
- `mem_ack` input, 1 bit: a transfer occurs on a cycle where `mem_req && mem_ack`.
- `mem_rdata` input, `DATA_W` bits: read data, valid with `mem_ack`.
- `buf_we` output, 1 bit: buffer write enable, `= mem_req & mem_ack & ~mem_we`.
- `buf_sel` output, 1 bit: 0 = input buffer, 1 = weight buffer.
- `buf_addr` output, 16 bits: buffer word address.
- `buf_wdata` output, `DATA_W` bits: `= mem_rdata`.
- `obuf_raddr` output, 12 bits: output-buffer read address.
- `obuf_rdata` input, `DATA_W` bits: output-buffer data, one-cycle read latency.
- `pe_start` output, 1 bit: one-cycle pulse to start the PE array.
- `pe_done` input, 1 bit: PE array finished the current partition.

## Operation
States: IDLE, LD, PE_START, PE_WAIT, SOF_RD, SOF_WR, DONE.

- **IDLE:** on a start, latch `fc_cin`, `fc_cout` and `base_addr`, and clear the counters. Priority when several starts are high: LIF > LW > SOF.
  - Zero-length command goes straight to DONE with no memory traffic: `cin==0` for LIF; `cin==0` or `cout==0` for LW; `cout==0` for SOF.
  - Otherwise LIF and LW go to LD; SOF goes to SOF_RD.
- **LD:**
  - Drives `mem_req=1`, `mem_we=0`, `mem_addr = base + lin`.
  - `lin` is a linear word counter: `lin` is 24 bits; the sum wraps modulo 2^27.
  - `buf_addr` = word index within the current partition (LIF: `lin`).
  - On each ack: `lin++` and the partition index increments.
  - LIF: after the ack for word `cin-1`, go to DONE.
  - LW: a partition holds `rows*cin` words, where `rows = min(PART_ROWS, cout - p*PART_ROWS)`. The ack of its last word goes to PE_START and the partition index resets to 0.
- **PE_START:** `pe_start=1` for one cycle, then go to PE_WAIT.
- **PE_WAIT:** wait for `pe_done`.
  - Final partition: go to DONE.
  - Otherwise: pulse `fc_next_partition` in that cycle and return to LD.
- **SOF_RD:** `obuf_raddr = idx`, then go to SOF_WR.
- **SOF_WR:**
  - Drives `mem_req=1`, `mem_we=1`, `mem_addr = base + idx`, `mem_wdata = obuf_rdata`.
  - `obuf_raddr` is held, so the data stays stable while waiting for ack.
  - On ack: `idx++`. If `idx == cout-1`, go to DONE; else go to SOF_RD.
- **DONE:** `fc_done=1` for one cycle, then go to IDLE. The decoder drops the start level on the same edge, so no re-trigger occurs.
- **Reset or `fc_rst`:** return to IDLE from any state, including mid-transfer.
  - All outputs go to 0: `fc_done`, `fc_next_partition`, `mem_req`, `mem_we`, `pe_start`, `buf_we`, all addresses and `mem_wdata`.
  - Counters are cleared; any outstanding request is dropped.

## Timing
- The start is sampled at edge n; `mem_req` rises in cycle n+1.
- Reads sustain 1 word/cycle when `mem_ack` is held high. `mem_addr` advances in the cycle after each ack.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable until ack. Stalls (`mem_ack=0`) may be of any length.
- The buffer write for the final word happens in the ack cycle, so the buffer is complete before `pe_start` or `fc_done`.
- Stores take 2 cycles/word with no stall.
- Latency to `fc_done`:
  - LIF: `cin+2` cycles from accept with ack always high.
  - SOF: `2*cout+2`.
  - Zero-length: 2.
- `pe_done` asserted while in PE_START is ignored; only PE_WAIT samples it.
- `PART_ROWS*cin` must fit in 16 bits: 16*4095 < 65536 at the default.

## Test plan
- **LIF:** `cin=4`, `base=0x100`, ack always high → reads at 0x100–0x103 on 4 consecutive cycles; `buf_sel=0`, `buf_addr` 0–3; one `fc_done` pulse; no further requests.
- **LW partitioning:** `cin=3`, `cout=20`, `PART_ROWS=16`.
  - 48 reads (`buf_addr` 0–47), then `pe_start`.
  - `pe_done` → `fc_next_partition` pulse.
  - 12 reads at `base+48..59` (`buf_addr` 0–11), then `pe_start`.
  - `pe_done` → `fc_done`, with no second `fc_next_partition`.
- **SOF:** `cout=2`, `base=0x7FFFFFF`, `obuf_rdata = 0xA, 0xB` → writes of 0xA at 0x7FFFFFF and 0xB at 0x0000000 (address wrap); then `fc_done`.
- **Backpressure:** LIF `cin=2` with `mem_ack` low for 3 cycles on the first word → `mem_addr` and `mem_req` stable for 4 cycles; exactly 2 `buf_we` pulses.
- **Zero-length and priority:** `fc_lw_start` with `cout=0` → `fc_done` 2 cycles after accept, `mem_req` never high. `fc_lif_start` and `fc_sof_start` both high → LIF executes.
- **Abort:** `rst_n=0` or `fc_rst=1` mid-LD → next cycle IDLE, all outputs 0. A new LIF then restarts at `base+0`.

Source files
------------

// File: rtl/fc_controller.sv
// fc_controller: FC engine sequencer for input-feature loads, partitioned weight loads and output-feature stores
module fc_controller #(
  parameter int PART_ROWS = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fc_rst,
  input  logic [11:0]       fc_cin,
  input  logic [11:0]       fc_cout,
  input  logic              fc_lif_start,
  input  logic              fc_lw_start,
  input  logic              fc_sof_start,
  input  logic [26:0]       base_addr,
  output logic              fc_next_partition,
  output logic              fc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [26:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [15:0]       buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [11:0]       obuf_raddr,
  input  logic [DATA_W-1:0] obuf_rdata,
  output logic              pe_start,
  input  logic              pe_done
);
  typedef enum logic [2:0] {IDLE, LD, PE_START, PE_WAIT, SOF_RD, SOF_WR, DONE} state_e;
  localparam logic [12:0] PR = 13'(PART_ROWS);
  state_e      state_q;
  logic [11:0] cin_q, rem_q;
  logic [26:0] base_q;
  logic        lw_q, done_q;
  logic [23:0] lin_q;
  logic [15:0] widx_q;
  logic        ld_d, wr_d, last_part_d;
  logic [11:0] rows_d;
  logic [15:0] part_words_d;
  // rem_q counts output rows not yet loaded; for SOF it simply holds cout
  assign ld_d = state_q == LD;
  assign wr_d = state_q == SOF_WR;
  assign last_part_d = {1'b0, rem_q} <= PR;
  assign rows_d = last_part_d ? rem_q : PR[11:0];
  assign part_words_d = {4'b0, rows_d} * {4'b0, cin_q};
  // memory and buffer ports decoded from state; lin_q doubles as the store index
  assign mem_req = ld_d || wr_d;
  assign mem_we = wr_d;
  assign mem_addr = mem_req ? base_q + 27'(lin_q) : '0;
  assign mem_wdata = wr_d ? obuf_rdata : '0;
  assign buf_we = mem_req & mem_ack & ~mem_we;
  assign buf_sel = ld_d & lw_q;
  assign buf_addr = ld_d ? widx_q : '0;
  assign buf_wdata = mem_rdata;
  assign obuf_raddr = (state_q == SOF_RD || wr_d) ? lin_q[11:0] : '0;
  assign pe_start = state_q == PE_START;
  assign fc_next_partition = state_q == PE_WAIT && pe_done && !last_part_d;
  assign fc_done = done_q;
  // command sequencer; done_q blocks re-accept while the decoder is still dropping its start level
  always_ff @(posedge clk) begin
    if (!rst_n || fc_rst) begin
      state_q <= IDLE;
      cin_q <= '0;
      rem_q <= '0;
      base_q <= '0;
      lw_q <= 1'b0;
      done_q <= 1'b0;
      lin_q <= '0;
      widx_q <= '0;
    end else begin
      done_q <= state_q == DONE;
      case (state_q)
        IDLE: if (!done_q && (fc_lif_start || fc_lw_start || fc_sof_start)) begin
          cin_q <= fc_cin;
          rem_q <= fc_cout;
          base_q <= base_addr;
          lin_q <= '0;
          widx_q <= '0;
          lw_q <= !fc_lif_start && fc_lw_start;
          if (fc_lif_start) state_q <= fc_cin == 12'd0 ? DONE : LD;
          else if (fc_lw_start) state_q <= (fc_cin == 12'd0 || fc_cout == 12'd0) ? DONE : LD;
          else state_q <= fc_cout == 12'd0 ? DONE : SOF_RD;
        end
        LD: if (mem_ack) begin
          lin_q <= lin_q + 24'd1;
          widx_q <= widx_q + 16'd1;
          if (!lw_q && lin_q == {12'b0, cin_q} - 24'd1) state_q <= DONE;
          else if (lw_q && widx_q == part_words_d - 16'd1) begin
            widx_q <= '0;
            state_q <= PE_START;
          end
        end
        PE_START: state_q <= PE_WAIT;
        PE_WAIT: if (pe_done) begin
          if (last_part_d) state_q <= DONE;
          else begin
            rem_q <= rem_q - PR[11:0];
            state_q <= LD;
          end
        end
        SOF_RD: state_q <= SOF_WR;
        SOF_WR: if (mem_ack) begin
          lin_q <= lin_q + 24'd1;
          state_q <= lin_q[11:0] == rem_q - 12'd1 ? DONE : SOF_RD;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_controller.sv
// tb_fc_controller: scoreboard bench for fc_controller
module tb_fc_controller;
  logic        clk, rst_n, fc_rst;
  logic [11:0] fc_cin, fc_cout;
  logic        fc_lif_start, fc_lw_start, fc_sof_start;
  logic [26:0] base_addr;
  logic        fc_next_partition, fc_done, mem_req, mem_we;
  logic [26:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, buf_wdata, obuf_rdata;
  logic        mem_ack, buf_we, buf_sel, pe_start, pe_done, ack_en;
  logic [15:0] buf_addr;
  logic [11:0] obuf_raddr;

  typedef struct {
    bit          we;
    logic [26:0] addr;
    logic [31:0] data;
    logic [15:0] baddr;
    bit          sel;
  } xfer_t;

  xfer_t exp_q[$];
  int    exp_pe[$];
  int    total = 0, bad = 0;
  int    n_xfer = 0, done_cnt = 0, next_cnt = 0, pe_cnt = 0, bufwe_cnt = 0, req_cyc = 0;

  fc_controller dut (
    .clk(clk), .rst_n(rst_n), .fc_rst(fc_rst),
    .fc_cin(fc_cin), .fc_cout(fc_cout),
    .fc_lif_start(fc_lif_start), .fc_lw_start(fc_lw_start), .fc_sof_start(fc_sof_start),
    .base_addr(base_addr),
    .fc_next_partition(fc_next_partition), .fc_done(fc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .obuf_raddr(obuf_raddr), .obuf_rdata(obuf_rdata),
    .pe_start(pe_start), .pe_done(pe_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [26:0] a);
    return {5'b0, a} ^ 32'hC300_0000;
  endfunction

  assign mem_ack = ack_en;
  assign mem_rdata = rd_model(mem_addr);

  // output buffer with one-cycle read latency
  always @(posedge clk) obuf_rdata <= 32'h0000_000A + 32'(obuf_raddr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input logic [26:0] a, input logic [15:0] ba, input bit sel);
    xfer_t e;
    e.we = 1'b0; e.addr = a; e.data = rd_model(a); e.baddr = ba; e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [26:0] a, input logic [31:0] d);
    xfer_t e;
    e.we = 1'b1; e.addr = a; e.data = d; e.baddr = '0; e.sel = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_done"}, fc_done, 0);
    check({tag, "_next"}, fc_next_partition, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_bufwe"}, buf_we, 0);
    check({tag, "_bufaddr"}, buf_addr, 0);
    check({tag, "_oraddr"}, obuf_raddr, 0);
    check({tag, "_pestart"}, pe_start, 0);
  endtask

  // called just after the accept edge; n ends as cycles from accept to the fc_done cycle
  task automatic finish_cmd(input string tag, output int n);
    n = 0;
    while (!fc_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, fc_done, 1);
    @(posedge clk);
    #1;
    fc_lif_start = 0; fc_lw_start = 0; fc_sof_start = 0;
  endtask

  task automatic run_lif(input string tag, input int cin, input logic [26:0] base, input bit sof_too);
    int d0, n;
    for (int i = 0; i < cin; i++) push_rd(base + 27'(i), 16'(i), 1'b0);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    fc_cin = 12'(cin); fc_cout = 12'd2; base_addr = base;
    fc_lif_start = 1; fc_sof_start = sof_too;
    @(posedge clk);
    finish_cmd(tag, n);
    check({tag, "_lat"}, n, cin + 2);
    repeat (3) @(posedge clk);
    check({tag, "_q"}, exp_q.size(), 0);
    check({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  task automatic abort_test(input string tag, input bit use_rstn);
    for (int i = 0; i < 3; i++) push_rd(27'h300 + 27'(i), 16'(i), 1'b0);
    @(posedge clk);
    #1;
    fc_cin = 12'd8; base_addr = 27'h300; fc_lif_start = 1;
    repeat (3) @(posedge clk);
    #1;
    if (use_rstn) rst_n = 0;
    else fc_rst = 1;
    fc_lif_start = 0;
    @(posedge clk);
    #1;
    rst_n = 1; fc_rst = 0;
    @(negedge clk);
    chk_idle(tag);
    check({tag, "_q"}, exp_q.size(), 0);
    run_lif({tag, "_restart"}, 2, 27'h300, 1'b0);
  endtask

  // monitor: pops the scoreboard on every transfer and tallies pulses
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) req_cyc++;
      if (buf_we === 1'b1) bufwe_cnt++;
      if (fc_done === 1'b1) done_cnt++;
      if (fc_next_partition === 1'b1) begin
        next_cnt++;
        check("next_with_pe_done", pe_done, 1);
      end
      if (pe_start === 1'b1) begin
        pe_cnt++;
        check("pe_avail", exp_pe.size() > 0, 1);
        if (exp_pe.size() > 0) check("pe_after_xfers", n_xfer, exp_pe.pop_front());
      end
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        n_xfer++;
        check("xfer_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("we", mem_we, e.we);
          check("addr", mem_addr, e.addr);
          if (e.we) begin
            check("wdata", mem_wdata, e.data);
            check("bufwe_on_wr", buf_we, 0);
          end else begin
            check("bufwe", buf_we, 1);
            check("buf_addr", buf_addr, e.baddr);
            check("buf_sel", buf_sel, e.sel);
            check("buf_wdata", buf_wdata, e.data);
          end
        end
      end
    end
  end

  // PE array model: finishes each partition two cycles after pe_start
  initial begin
    forever begin
      @(negedge clk);
      if (pe_start === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 pe_done = 1;
        @(posedge clk);
        #1 pe_done = 0;
      end
    end
  end

  initial begin
    int n, d0, p0;
    rst_n = 0; fc_rst = 0; fc_cin = 0; fc_cout = 0; base_addr = 0;
    fc_lif_start = 0; fc_lw_start = 0; fc_sof_start = 0; pe_done = 0; ack_en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_idle("reset");

    run_lif("lif4", 4, 27'h100, 1'b0);

    // weight load: cin=3, cout=20 -> partitions of 16 and 4 rows
    for (int i = 0; i < 48; i++) push_rd(27'h1000 + 27'(i), 16'(i), 1'b1);
    for (int i = 0; i < 12; i++) push_rd(27'h1000 + 27'(48 + i), 16'(i), 1'b1);
    exp_pe.push_back(n_xfer + 48);
    exp_pe.push_back(n_xfer + 60);
    d0 = next_cnt; p0 = pe_cnt;
    @(posedge clk);
    #1;
    fc_cin = 12'd3; fc_cout = 12'd20; base_addr = 27'h1000; fc_lw_start = 1;
    @(posedge clk);
    finish_cmd("lw", n);
    repeat (3) @(posedge clk);
    check("lw_q", exp_q.size(), 0);
    check("lw_pe_q", exp_pe.size(), 0);
    check("lw_npe", pe_cnt - p0, 2);
    check("lw_nnext", next_cnt - d0, 1);

    // store with address wrap
    push_wr(27'h7FF_FFFF, 32'hA);
    push_wr(27'h000_0000, 32'hB);
    @(posedge clk);
    #1;
    fc_cin = 12'd0; fc_cout = 12'd2; base_addr = 27'h7FF_FFFF; fc_sof_start = 1;
    @(posedge clk);
    finish_cmd("sof", n);
    check("sof_lat", n, 6);
    repeat (3) @(posedge clk);
    check("sof_q", exp_q.size(), 0);

    // backpressure on first word
    push_rd(27'h400, 16'd0, 1'b0);
    push_rd(27'h401, 16'd1, 1'b0);
    d0 = bufwe_cnt;
    @(posedge clk);
    #1;
    ack_en = 0; fc_cin = 12'd2; base_addr = 27'h400; fc_lif_start = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req", mem_req, 1);
      check("bp_addr", mem_addr, 27'h400);
    end
    @(posedge clk);
    #1 ack_en = 1;
    @(negedge clk);
    check("bp_req4", mem_req, 1);
    check("bp_addr4", mem_addr, 27'h400);
    finish_cmd("bp", n);
    repeat (3) @(posedge clk);
    check("bp_q", exp_q.size(), 0);
    check("bp_nbufwe", bufwe_cnt - d0, 2);

    // zero-length weight load
    d0 = req_cyc; p0 = done_cnt;
    @(posedge clk);
    #1;
    fc_cin = 12'd5; fc_cout = 12'd0; base_addr = 27'h500; fc_lw_start = 1;
    @(posedge clk);
    finish_cmd("zero", n);
    check("zero_lat", n, 2);
    repeat (3) @(posedge clk);
    check("zero_req", req_cyc - d0, 0);
    check("zero_ndone", done_cnt - p0, 1);

    run_lif("prio", 3, 27'h200, 1'b1);

    for (int k = 0; k < 3; k++) run_lif("lif_rand", int'($urandom_range(1, 9)), 27'($urandom), 1'b0);

    abort_test("abort_fcrst", 1'b0);
    abort_test("abort_rstn", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
